// File: rtl/race_control.sv
// Race game-flow controller: sequences idle, ready countdown, run and finish,
// drives the seconds counter's enable/clear and keeps the best finish time.
module race_control #(
  parameter int TICK_COUNT = 50_000_000,
  parameter int READY_SECS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       finish,
  input  logic [3:0] time_ones,
  input  logic [3:0] time_tens,
  output logic       timer_enable,
  output logic       timer_clear_n,
  output logic [1:0] state,
  output logic [3:0] countdown,
  output logic [3:0] best_ones,
  output logic [3:0] best_tens,
  output logic       best_valid,
  output logic       new_record,
  output logic       timed_out
);

  localparam int            TW          = $clog2(TICK_COUNT);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_COUNT - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [3:0]    READY_LOAD  = 4'(READY_SECS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // BCD digits compare correctly as plain unsigned bytes.
  function automatic logic is_faster(input logic [7:0] cand, input logic [7:0] best,
                                     input logic valid);
    is_faster = !valid || (cand < best);
  endfunction

  logic          start_s1_r, start_s2_r, start_prev_r;
  logic          finish_s1_r, finish_s2_r, finish_prev_r;
  logic          start_edge_s, finish_edge_s, at_limit_s, take_best_s;
  state_t        state_r, state_nxt_s;
  logic [TW-1:0] tick_r, tick_nxt_s;
  logic [3:0]    countdown_r, countdown_nxt_s;
  logic          timed_out_r, timed_out_nxt_s;
  logic          capture_r, capture_nxt_s;
  logic          enable_r, clear_n_r;
  logic [3:0]    best_ones_r, best_tens_r;
  logic          best_valid_r, new_record_r;

  // Two-flop synchronizers plus previous-value flops for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_s1_r    <= 1'b0;
      start_s2_r    <= 1'b0;
      start_prev_r  <= 1'b0;
      finish_s1_r   <= 1'b0;
      finish_s2_r   <= 1'b0;
      finish_prev_r <= 1'b0;
    end else begin
      start_s1_r    <= start;
      start_s2_r    <= start_s1_r;
      start_prev_r  <= start_s2_r;
      finish_s1_r   <= finish;
      finish_s2_r   <= finish_s1_r;
      finish_prev_r <= finish_s2_r;
    end
  end

  assign start_edge_s  = start_s2_r & ~start_prev_r;
  assign finish_edge_s = finish_s2_r & ~finish_prev_r;
  assign at_limit_s    = (time_tens == 4'd9) && (time_ones == 4'd9);
  assign take_best_s   = capture_r &&
                         is_faster({time_tens, time_ones}, {best_tens_r, best_ones_r}, best_valid_r);

  // Next-state and datapath decode for the race sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    tick_nxt_s      = tick_r;
    countdown_nxt_s = countdown_r;
    timed_out_nxt_s = timed_out_r;
    capture_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_nxt_s     = READY;
          countdown_nxt_s = READY_LOAD;
          tick_nxt_s      = TICK_RELOAD;
          timed_out_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READY: begin
        if (!start_s2_r) begin
          state_nxt_s     = IDLE;
          countdown_nxt_s = 4'd0;
        end else if (tick_r == '0) begin
          tick_nxt_s = TICK_RELOAD;
          if (countdown_r == 4'd1) begin
            state_nxt_s     = RUN;
            countdown_nxt_s = 4'd0;
          end else begin
            countdown_nxt_s = countdown_r - 4'd1;
          end
        end else begin
          tick_nxt_s = tick_r - TICK_ONE;
        end
      end
      RUN: begin
        if (!start_s2_r) begin
          state_nxt_s = IDLE;
        end else if (finish_edge_s) begin
          state_nxt_s   = DONE;
          capture_nxt_s = 1'b1;
        end else if (at_limit_s) begin
          state_nxt_s     = DONE;
          timed_out_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (!start_s2_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters, counter controls and best-time record.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      tick_r       <= '0;
      countdown_r  <= 4'd0;
      timed_out_r  <= 1'b0;
      capture_r    <= 1'b0;
      enable_r     <= 1'b0;
      clear_n_r    <= 1'b0;
      best_ones_r  <= 4'd0;
      best_tens_r  <= 4'd0;
      best_valid_r <= 1'b0;
      new_record_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      tick_r       <= tick_nxt_s;
      countdown_r  <= countdown_nxt_s;
      timed_out_r  <= timed_out_nxt_s;
      capture_r    <= capture_nxt_s;
      enable_r     <= (state_nxt_s == RUN);
      clear_n_r    <= (state_nxt_s == RUN) || (state_nxt_s == DONE);
      new_record_r <= take_best_s;
      if (take_best_s) begin
        best_ones_r  <= time_ones;
        best_tens_r  <= time_tens;
        best_valid_r <= 1'b1;
      end
    end
  end

  assign state         = state_r;
  assign countdown     = countdown_r;
  assign timed_out     = timed_out_r;
  assign timer_enable  = enable_r;
  assign timer_clear_n = clear_n_r;
  assign best_ones     = best_ones_r;
  assign best_tens     = best_tens_r;
  assign best_valid    = best_valid_r;
  assign new_record    = new_record_r;

endmodule

// File: tb/tb_race_control.sv
// Self-checking bench for race_control: directed flow plus random races
// scored against a simple best-time model.
module tb_race_control;

  localparam int TICK_COUNT = 4;
  localparam int READY_SECS = 3;

  logic       clock = 1'b0;
  logic       reset_n, start, finish;
  logic [3:0] time_ones, time_tens;
  logic       timer_enable, timer_clear_n;
  logic [1:0] state;
  logic [3:0] countdown, best_ones, best_tens;
  logic       best_valid, new_record, timed_out;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_best = 0;
  bit exp_valid = 1'b0;

  race_control #(.TICK_COUNT(TICK_COUNT), .READY_SECS(READY_SECS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .finish(finish),
    .time_ones(time_ones), .time_tens(time_tens),
    .timer_enable(timer_enable), .timer_clear_n(timer_clear_n),
    .state(state), .countdown(countdown),
    .best_ones(best_ones), .best_tens(best_tens), .best_valid(best_valid),
    .new_record(new_record), .timed_out(timed_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_best(input string tag);
    check({tag, "_ones"}, 8'(best_ones), 8'(exp_best % 10));
    check({tag, "_tens"}, 8'(best_tens), 8'(exp_best / 10));
    check({tag, "_valid"}, 8'(best_valid), 8'(exp_valid));
  endtask

  task automatic set_time(input int t);
    time_tens = 4'(t / 10);
    time_ones = 4'(t % 10);
  endtask

  // Raise start, check the 3-cycle latency and the full countdown into RUN.
  task automatic begin_race();
    start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("start_latency", 8'(state), (k == 3) ? 8'd1 : 8'd0);
    end
    for (int k = 0; k < READY_SECS * TICK_COUNT; k++) begin
      check("ready_state", 8'(state), 8'd1);
      check("countdown", 8'(countdown), 8'(READY_SECS - k / TICK_COUNT));
      check("ready_ctrl", 8'({timer_enable, timer_clear_n}), 8'd0);
      check("ready_timed_out", 8'(timed_out), 8'd0);
      step();
    end
    check("run_state", 8'(state), 8'd2);
    check("run_ctrl", 8'({timer_enable, timer_clear_n}), 8'd3);
    check("run_countdown", 8'(countdown), 8'd0);
  endtask

  // Finish at time t; the time is applied in the cycle the finish edge is seen.
  task automatic finish_race(input int t);
    logic rec;
    finish = 1'b1;
    step();
    step();
    check("finish_latency", 8'(state), 8'd2);
    set_time(t);
    step();
    check("done_state", 8'(state), 8'd3);
    check("done_ctrl", 8'({timer_enable, timer_clear_n}), 8'd1);
    check("done_timed_out", 8'(timed_out), 8'd0);
    check("nr_before", 8'(new_record), 8'd0);
    finish = 1'b0;
    rec = !exp_valid || (t < exp_best);
    if (rec) begin
      exp_best  = t;
      exp_valid = 1'b1;
    end
    step();
    check("new_record", 8'(new_record), 8'(rec));
    check_best("capture");
    step();
    check("nr_after", 8'(new_record), 8'd0);
    check_best("hold");
  endtask

  task automatic timeout_race();
    set_time(99);
    step();
    check("to_state", 8'(state), 8'd3);
    check("to_flag", 8'(timed_out), 8'd1);
    check("to_ctrl", 8'({timer_enable, timer_clear_n}), 8'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      check("to_nr", 8'(new_record), 8'd0);
      check_best("to_best");
    end
  endtask

  // Drop start from RUN or DONE; IDLE follows three edges later.
  task automatic leave(input logic [7:0] from_st);
    start = 1'b0;
    step();
    step();
    check("leave_hold", 8'(state), from_st);
    step();
    check("leave_idle", 8'(state), 8'd0);
    check("leave_ctrl", 8'({timer_enable, timer_clear_n}), 8'd0);
    check("leave_nr", 8'(new_record), 8'd0);
    check_best("leave_best");
    set_time(0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    finish  = 1'b0;
    set_time(0);
    step();
    step();
    check("rst_state", 8'(state), 8'd0);
    check("rst_ctrl", 8'({timer_enable, timer_clear_n}), 8'd0);
    check("rst_countdown", 8'(countdown), 8'd0);
    check("rst_flags", 8'({new_record, timed_out}), 8'd0);
    check_best("rst_best");
    reset_n = 1'b1;
    step();

    // finish is ignored in IDLE
    finish = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("idle_finish", 8'(state), 8'd0);
    end
    finish = 1'b0;
    repeat (3) step();

    // Finish and 99 together: finish wins and 99 is captured as first best
    begin_race();
    finish_race(99);
    leave(8'd3);

    begin_race(); finish_race(12); leave(8'd3);
    begin_race(); finish_race(15); leave(8'd3);
    begin_race(); finish_race(7);  leave(8'd3);
    begin_race(); finish_race(7);  leave(8'd3);

    // Timeout, flag persists into IDLE and clears on the next READY entry
    begin_race();
    timeout_race();
    leave(8'd3);
    check("to_persist", 8'(timed_out), 8'd1);

    // Abort from RUN
    begin_race();
    leave(8'd2);

    // finish ignored in READY, then abort from READY
    start = 1'b1;
    repeat (3) step();
    check("abort_ready_entry", 8'(state), 8'd1);
    finish = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) finish = 1'b0;
      check("ready_finish_state", 8'(state), 8'd1);
      check("ready_finish_cd", 8'(countdown), 8'(READY_SECS - k / TICK_COUNT));
    end
    start = 1'b0;
    step();
    step();
    check("abort_ready_hold", 8'(state), 8'd1);
    step();
    check("abort_ready_idle", 8'(state), 8'd0);
    check("abort_ready_cd", 8'(countdown), 8'd0);
    check_best("abort_ready_best");

    // Random races against the best-time model
    for (int i = 0; i < 12; i++) begin
      int mode;
      mode = int'($urandom_range(0, 9));
      begin_race();
      if (mode == 0) begin
        leave(8'd2);
      end else if (mode == 1) begin
        timeout_race();
        leave(8'd3);
      end else begin
        finish_race(int'($urandom_range(0, 99)));
        leave(8'd3);
      end
    end

    // Asynchronous reset mid-READY
    begin_race();
    timeout_race();
    leave(8'd3);
    start = 1'b1;
    repeat (5) step();
    check("pre_rst_state", 8'(state), 8'd1);
    #2 reset_n = 1'b0;
    exp_best  = 0;
    exp_valid = 1'b0;
    #1;
    check("arst_state", 8'(state), 8'd0);
    check("arst_ctrl", 8'({timer_enable, timer_clear_n}), 8'd0);
    check("arst_countdown", 8'(countdown), 8'd0);
    check("arst_flags", 8'({new_record, timed_out}), 8'd0);
    check_best("arst_best");
    start = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_state", 8'(state), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
